systolic_feeder: RTL and testbench

Input-side skew feeder for the systolic matrix unit. It buffers one ARRAY_SIZE×ARRAY_SIZE activation tile, loaded one element per beat over a valid/ready handshake. It then streams the tile into the array rows with the diagonal skew the processing elements require: row i lags row i-1 by one cycle. It sits between the activation memory and the row inputs of the PE grid and produces the row stimulus that the array consumes.

---
 rtl/systolic_feeder.sv | 126 ++++++++++++
 tb/tb_systolic_feeder.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/systolic_feeder.sv
// Activation skew feeder: buffers one NxN tile, then streams it into the
// PE rows with a one-cycle lag per row.
`ifndef DATA_W
`define DATA_W 8
`endif

module systolic_feeder #(
  parameter int ARRAY_SIZE = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           load_valid,
  output logic                           load_ready,
  input  logic [`DATA_W-1:0]             load_data,
  input  logic                           hold,
  output logic [ARRAY_SIZE*`DATA_W-1:0]  row_data,
  output logic [ARRAY_SIZE-1:0]          row_valid,
  output logic                           busy,
  output logic                           done
);

  localparam int N      = ARRAY_SIZE;
  localparam int DW     = `DATA_W;
  localparam int NN     = N * N;
  localparam int IDX_W  = $clog2(NN);
  localparam int T_W    = $clog2(2 * N - 1);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NN - 1);
  localparam logic [T_W-1:0]   LAST_T   = T_W'(2 * N - 2);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STREAM,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [T_W-1:0]   t_q, t_d;
  logic [DW-1:0]    buf_q [NN];
  logic [DW-1:0]    buf_d [NN];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    t_d     = t_q;
    buf_d   = buf_q;
    unique case (state_q)
      IDLE: begin
        if (load_valid) begin
          buf_d[0] = load_data;
          idx_d    = IDX_W'(1);
          state_d  = LOAD;
        end
      end
      LOAD: begin
        if (load_valid) begin
          buf_d[idx_q] = load_data;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            t_d     = '0;
            state_d = STREAM;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      STREAM: begin
        // hold freezes t, and with it every output lane
        if (!hold) begin
          if (t_q == LAST_T) begin
            t_d     = '0;
            state_d = DONE;
          end else begin
            t_d = t_q + T_W'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      t_q     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      t_q     <= t_d;
    end
  end

  // Tile storage has no reset; its contents only matter after a full load.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign load_ready = (state_q == IDLE) || (state_q == LOAD);
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);

  // Lane i shows A[i][k] when t == i + k.
  always_comb begin
    row_data  = '0;
    row_valid = '0;
    if (state_q == STREAM) begin
      for (int i = 0; i < N; i++) begin
        for (int k = 0; k < N; k++) begin
          if (t_q == T_W'(i + k)) begin
            row_data[i*DW +: DW] = buf_q[i*N+k];
            row_valid[i]         = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder: table of skewed beats for the
// 4x4 tile A[i][k]=4i+k+1 plus stall, gap, reset and spurious-load cases.
`timescale 1ns/1ps

module tb_systolic_feeder;

  logic        clk;
  logic        rst;
  logic        load_valid;
  logic        load_ready;
  logic [7:0]  load_data;
  logic        hold;
  logic [31:0] row_data;
  logic [3:0]  row_valid;
  logic        busy;
  logic        done;

  systolic_feeder #(.ARRAY_SIZE(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .hold       (hold),
    .row_data   (row_data),
    .row_valid  (row_valid),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] l3;
    logic [7:0] l2;
    logic [7:0] l1;
    logic [7:0] l0;
    logic [3:0] v;
  } beat_t;

  beat_t tbl [7];
  int nvec;
  int nerr;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_rd(input int t, input bit all5);
    logic [31:0] r;
    r = {tbl[t].l3, tbl[t].l2, tbl[t].l1, tbl[t].l0};
    if (all5) begin
      for (int i = 0; i < 4; i++)
        r[i*8 +: 8] = tbl[t].v[i] ? 8'd5 : 8'd0;
    end
    return r;
  endfunction

  task automatic load_tile(input bit gappy, input bit all5, input bit spur);
    for (int e = 0; e < 16; e++) begin
      if (gappy) begin
        load_valid = 1'b0;
        load_data  = 8'hEE;
        step();
      end
      chk("load_ready", {31'd0, load_ready}, 32'd1);
      load_valid = 1'b1;
      load_data  = all5 ? 8'd5 : 8'(e + 1);
      step();
    end
    load_valid = spur;
    load_data  = spur ? 8'd99 : 8'd0;
  endtask

  task automatic stream(input int hold_at, input int hold_len,
                        input bit all5);
    for (int t = 0; t < 7; t++) begin
      chk($sformatf("row_data t%0d", t), row_data, exp_rd(t, all5));
      chk($sformatf("row_valid t%0d", t), {28'd0, row_valid},
          {28'd0, tbl[t].v});
      chk("ready_in_stream", {31'd0, load_ready}, 32'd0);
      if (t == hold_at) begin
        hold = 1'b1;
        for (int h = 0; h < hold_len; h++) begin
          step();
          chk($sformatf("held row_data t%0d", t), row_data, exp_rd(t, all5));
          chk($sformatf("held row_valid t%0d", t), {28'd0, row_valid},
              {28'd0, tbl[t].v});
          chk("no_done_in_hold", {31'd0, done}, 32'd0);
        end
        hold = 1'b0;
      end
      step();
    end
    chk("done_pulse", {31'd0, done}, 32'd1);
    chk("busy_in_done", {31'd0, busy}, 32'd1);
    chk("ready_in_done", {31'd0, load_ready}, 32'd0);
    chk("row_valid_done", {28'd0, row_valid}, 32'd0);
    chk("row_data_done", row_data, 32'd0);
    load_valid = 1'b0;
    load_data  = 8'd0;
    step();
    chk("done_clear", {31'd0, done}, 32'd0);
    chk("ready_idle", {31'd0, load_ready}, 32'd1);
    chk("busy_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    tbl[0] = '{l0: 8'd1, l1: 8'd0, l2: 8'd0,  l3: 8'd0,  v: 4'b0001};
    tbl[1] = '{l0: 8'd2, l1: 8'd5, l2: 8'd0,  l3: 8'd0,  v: 4'b0011};
    tbl[2] = '{l0: 8'd3, l1: 8'd6, l2: 8'd9,  l3: 8'd0,  v: 4'b0111};
    tbl[3] = '{l0: 8'd4, l1: 8'd7, l2: 8'd10, l3: 8'd13, v: 4'b1111};
    tbl[4] = '{l0: 8'd0, l1: 8'd8, l2: 8'd11, l3: 8'd14, v: 4'b1110};
    tbl[5] = '{l0: 8'd0, l1: 8'd0, l2: 8'd12, l3: 8'd15, v: 4'b1100};
    tbl[6] = '{l0: 8'd0, l1: 8'd0, l2: 8'd0,  l3: 8'd16, v: 4'b1000};

    rst        = 1'b1;
    load_valid = 1'b0;
    load_data  = 8'd0;
    hold       = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("rst ready", {31'd0, load_ready}, 32'd1);
    chk("rst valid", {28'd0, row_valid}, 32'd0);
    chk("rst data", row_data, 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    step();
    step();
    rst = 1'b1;
    step();

    // hold in IDLE must be ignored
    hold = 1'b1;
    step();
    hold = 1'b0;

    load_tile(1'b0, 1'b0, 1'b0);
    stream(-1, 0, 1'b0);

    load_tile(1'b1, 1'b0, 1'b0);
    stream(-1, 0, 1'b0);

    load_tile(1'b0, 1'b0, 1'b0);
    stream(2, 3, 1'b0);

    load_tile(1'b0, 1'b0, 1'b1);
    stream(-1, 0, 1'b0);

    // abandon a tile mid-stream at t=4
    load_tile(1'b0, 1'b0, 1'b0);
    for (int t = 0; t < 4; t++) step();
    chk("pre-reset t4 data", row_data, exp_rd(4, 1'b0));
    #2 rst = 1'b0;
    #1;
    chk("mid rst data", row_data, 32'd0);
    chk("mid rst valid", {28'd0, row_valid}, 32'd0);
    chk("mid rst ready", {31'd0, load_ready}, 32'd1);
    chk("mid rst busy", {31'd0, busy}, 32'd0);
    #2 rst = 1'b1;
    step();
    load_tile(1'b0, 1'b1, 1'b0);
    stream(-1, 0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
